// File: rtl/message_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | message_scheduler: expands one 512-bit block into W[0..63] (SHA-256)     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module message_scheduler #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  MP_dv_in,
  output logic                  MS_ready_out,
  output logic [DATA_WIDTH-1:0] W_out,
  output logic [5:0]            W_idx_out,
  output logic                  W_valid_out,
  input  logic                  W_ready_in,
  output logic                  block_done_out,
  output logic                  overflow_out
);

  localparam int          C_WIN      = 16;
  localparam logic [3:0]  C_LAST_LD  = 4'd15;
  localparam logic [5:0]  C_LAST_T   = 6'd63;

  typedef enum logic [0:0] {
    S_LOAD = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            lcnt_q, lcnt_d;
  logic [5:0]            t_q, t_d;
  logic [DATA_WIDTH-1:0] win_q [C_WIN];
  logic [DATA_WIDTH-1:0] win_d [C_WIN];
  logic                  block_done_q, block_done_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] w_next;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Window holds W[t..t+15]; this is W[t+16], carries past bit 31 dropped.
  assign w_next = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];

  always_comb begin
    state_d      = state_q;
    lcnt_d       = lcnt_q;
    t_d          = t_q;
    win_d        = win_q;
    block_done_d = 1'b0;
    overflow_d   = overflow_q;

    case (state_q)
      S_LOAD: begin
        if (MP_dv_in) begin
          for (int i = 0; i < C_WIN - 1; i++) begin
            win_d[i] = win_q[i+1];
          end
          win_d[C_WIN-1] = data_in;
          lcnt_d         = lcnt_q + 4'd1;
          if (lcnt_q == C_LAST_LD) begin
            state_d = S_EMIT;
            lcnt_d  = 4'd0;
            t_d     = 6'd0;
          end
        end
      end

      S_EMIT: begin
        // The packer cannot stall, so a word arriving now is lost for good.
        if (MP_dv_in) begin
          overflow_d = 1'b1;
        end
        if (W_ready_in) begin
          for (int i = 0; i < C_WIN - 1; i++) begin
            win_d[i] = win_q[i+1];
          end
          win_d[C_WIN-1] = w_next;
          if (t_q == C_LAST_T) begin
            state_d      = S_LOAD;
            t_d          = 6'd0;
            block_done_d = 1'b1;
          end else begin
            t_d = t_q + 6'd1;
          end
        end
      end

      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_LOAD;
      lcnt_q       <= 4'd0;
      t_q          <= 6'd0;
      block_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      for (int i = 0; i < C_WIN; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      lcnt_q       <= lcnt_d;
      t_q          <= t_d;
      block_done_q <= block_done_d;
      overflow_q   <= overflow_d;
      for (int i = 0; i < C_WIN; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  assign MS_ready_out   = (state_q == S_LOAD);
  assign W_valid_out    = (state_q == S_EMIT);
  assign W_out          = W_valid_out ? win_q[0] : '0;
  assign W_idx_out      = t_q;
  assign block_done_out = block_done_q;
  assign overflow_out   = overflow_q;

endmodule
`default_nettype wire

// File: doc/message_scheduler.md
# message_scheduler

Downstream neighbour of the Message Packer in the SHA-256 datapath. It collects the 16 big-endian 32-bit words of one 512-bit padded block from the packer and expands them into the 64-entry message schedule W[0..63]. It presents one word per handshake to the compression core. Storage is a 16-word sliding window, with no 64-word RAM.

## Interface
- `DATA_WIDTH`, 32: word width; only 32 is supported.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `data_in` in 32: word from the Message Packer; word 0 of the block arrives first.
- `MP_dv_in` in 1: single-cycle strobe; `data_in` is valid on this cycle.
- `MS_ready_out` out 1: high while the block is accepting words (LOAD state).
- `W_out` out 32: current schedule word W[t].
- `W_idx_out` out 6: current index t.
- `W_valid_out` out 1: `W_out` and `W_idx_out` are valid (EMIT state).
- `W_ready_in` in 1: the compression core consumes the word when `W_valid_out` and `W_ready_in` are both high.
- `block_done_out` out 1: one-cycle pulse after W[63] is consumed.
- `overflow_out` out 1: sticky error flag; `MP_dv_in` arrived while `MS_ready_out` was low.

## Operation
- **Storage:** window registers `win[0..15]`, a 4-bit load counter `lcnt`, and a 6-bit emit counter `t`.
- **State LOAD:**
  - `MS_ready_out`=1.
  - Each `MP_dv_in` shifts the window: `win[i]`←`win[i+1]`, `win[15]`←`data_in`, `lcnt`+1.
  - After the 16th word (`lcnt`=15 and `MP_dv_in`), go to EMIT with `t`=0 and `lcnt`=0. At that point `win[i]`=W[i].
- **State EMIT:**
  - `W_valid_out`=1, `W_out`=`win[0]`, `W_idx_out`=`t`.
  - On each handshake, shift `win[i]`←`win[i+1]` for i<15, and load `win[15]`←σ1(`win[14]`)+`win[9]`+σ0(`win[1]`)+`win[0]` mod 2^32. This is W[t+16]. Then `t`+1.
  - Invariant: `win[i]`=W[t+i] at every cycle.
  - Words computed past W[63] are don't-care.
- **Arithmetic:**
  - σ0(x)=ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x)=ROTR17 ^ ROTR19 ^ SHR10.
  - Four-operand 32-bit add; carries out of bit 31 are discarded.
- **End of block:**
  - The handshake with `t`=63 returns the block to LOAD, clears `t`, and sets `block_done_out` for one cycle.
  - The next block loads immediately; the window contents are overwritten, not cleared.
- **Overflow:**
  - `MP_dv_in` while in EMIT drops the word and sets `overflow_out`=1.
  - `overflow_out` stays high until reset.
  - The packer has no stall, so the top level must not start the next block before `MS_ready_out` is high.
- **Reset (asynchronous, any time, including mid-LOAD or mid-EMIT):**
  - State=LOAD; `lcnt`, `t`, `win[*]` cleared.
  - Any partial block is discarded.
- **Output values during reset:**
  - `MS_ready_out`=1.
  - `W_valid_out`=0, `W_out`=0, `W_idx_out`=0.
  - `block_done_out`=0, `overflow_out`=0.

## Timing
- All outputs are registered or decoded directly from registered state; there is no combinational path from `data_in` or `W_ready_in` to any output.
- **Load-to-emit latency:** the 16th `MP_dv_in` is sampled at edge k. `W_valid_out`=1 with W[0] on `W_out` in the cycle after edge k.
- **Throughput:** with `W_ready_in` held high, one word per cycle. W[0]..W[63] take 64 consecutive cycles.
- **Done pulse:** W[63] is consumed at edge m. In the cycle after edge m, `block_done_out`=1, `MS_ready_out`=1 and `W_valid_out`=0.
- **Stall:** `W_ready_in`=0 holds `W_out`, `W_idx_out` and the window unchanged for any number of cycles.
- **LOAD input:** `MP_dv_in` may be asserted back-to-back or sparsely; gaps have no effect.
- **Simultaneous events:** `MP_dv_in` on the same edge as the final EMIT handshake is still in EMIT, so it is dropped and flags overflow.

## Test plan
- **Basic "abc" block:** after reset, send the 16 words 61626380, 0×14, 00000018 as sparse strobes, with `W_ready_in`=1.
  - W[0]=61626380 with `W_idx_out`=0.
  - W[15]=00000018.
  - W[16]=61626380, W[17]=000F0000.
  - W[63] is followed by exactly one `block_done_out` pulse; 64 valid cycles in total.
- **Back-pressure:** same block; toggle `W_ready_in` pseudo-randomly.
  - The W sequence matches the first scenario.
  - `W_out` and `W_idx_out` are stable during every ready-low cycle.
- **Back-to-back blocks:** load a second block immediately after `block_done_out`; second block = 16 words of FFFFFFFF.
  - W[0..15]=FFFFFFFF.
  - W[16] matches the reference model; no state from the first block leaks into the second.
- **Overflow:** pulse `MP_dv_in` with value DEADBEEF during EMIT at t=10.
  - `overflow_out` rises the next cycle and stays high.
  - The W sequence is unchanged.
- **Reset mid-EMIT:** assert `rst_n`=0 at t=30.
  - All outputs are at their reset values immediately, before the next clock edge.
  - After release, a fresh 16-word block reproduces the first scenario exactly.
- **Reset mid-LOAD:** reset after 7 of 16 words, then send a full block.
  - Output matches that block alone, with W[0] being the first post-reset word.
